// File: rtl/game_countdown_timer.sv
// Countdown game timer: binary count with tick/miss/bonus updates, game-over
// detection, a sequential double-dabble BCD converter and a registered
// multiplexed seven-segment scanner.
`timescale 1ns/1ps
module game_countdown_timer #(
   parameter int TICK_DIV  = 5000,
   parameter int COUNT_W   = 21,
   parameter int START     = 1800000,
   parameter int MAX_VALUE = 1999999,
   parameter int PENALTY   = 10,
   parameter int BONUS     = 10,
   parameter int DIGITS    = 8,
   parameter int DP_POS    = 4,
   parameter int MUX_BITS  = 6,
   parameter int AUTO_RUN  = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  miss,
   input  logic                  bonus,
   output logic [COUNT_W-1:0]    timer_out,
   output logic [4*DIGITS-1:0]   timer_bcd,
   output logic                  running,
   output logic                  game_over,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [7:0]            an
);

   localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int SW = COUNT_W + 2;
   localparam int IW = $clog2(COUNT_W + 1);
   localparam int BW = 4 * DIGITS;

   localparam logic [DW-1:0]        DIV_MAX = DW'(TICK_DIV - 1);
   localparam logic [COUNT_W-1:0]   START_C = COUNT_W'(START);
   localparam logic [COUNT_W-1:0]   MAX_C   = COUNT_W'(MAX_VALUE);
   localparam logic signed [SW-1:0] MAX_S   = SW'(MAX_VALUE);
   localparam logic signed [SW-1:0] PEN_S   = SW'(PENALTY);
   localparam logic signed [SW-1:0] BON_S   = SW'(BONUS);
   localparam logic signed [SW-1:0] ONE_S   = SW'(1);
   localparam logic signed [SW-1:0] ZERO_S  = SW'(0);
   localparam logic [IW-1:0]        IT_LAST = IW'(COUNT_W - 1);

   typedef enum logic [1:0] {CV_IDLE = 2'd0, CV_SHIFT = 2'd1, CV_DONE = 2'd2} cv_state_e;

   // Add 3 to every BCD digit that is 5 or more (double-dabble correction).
   function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
         else                     r[4*i +: 4] = v[4*i +: 4];
      end
      return r;
   endfunction

   // Seven-segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0111111;
         4'd1:    return 7'b0000110;
         4'd2:    return 7'b1011011;
         4'd3:    return 7'b1001111;
         4'd4:    return 7'b1100110;
         4'd5:    return 7'b1101101;
         4'd6:    return 7'b1111101;
         4'd7:    return 7'b0000111;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1101111;
         default: return 7'b1000000;
      endcase
   endfunction

   logic [COUNT_W-1:0] count_q, count_d;
   logic               run_q, run_d, go_q, go_d;
   logic [DW-1:0]      div_q, div_d;
   logic               active_s, tick_s;
   logic signed [SW-1:0] sum_s;

   cv_state_e          cv_q, cv_d;
   logic               req_q, req_d;
   logic [IW-1:0]      it_q, it_d;
   logic [COUNT_W-1:0] bin_q, bin_d;
   logic [BW-1:0]      bcd_q, bcd_d, adj_s;
   logic [BW-1:0]      timer_bcd_q, timer_bcd_d;

   logic [MUX_BITS-1:0] scan_q;
   logic [2:0]          sel_s;
   logic [31:0]         bcd32_s;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [7:0]          an_q, an_d;

   assign active_s = run_q & ~pause;
   assign tick_s   = active_s & (div_q == DIV_MAX);
   assign sum_s    = $signed({2'b00, count_q}) - (tick_s ? ONE_S : ZERO_S)
                   - (miss ? PEN_S : ZERO_S) + (bonus ? BON_S : ZERO_S);

   // Next count, divider, running and game-over state; start overrides updates.
   always_comb begin
      count_d = count_q;
      run_d   = run_q;
      go_d    = go_q;
      div_d   = div_q;
      if (start) begin
         count_d = START_C;
         run_d   = 1'b1;
         go_d    = 1'b0;
         div_d   = '0;
      end else if (active_s) begin
         div_d = tick_s ? '0 : div_q + 1'b1;
         if (sum_s[SW-1])       count_d = '0;
         else if (sum_s > MAX_S) count_d = MAX_C;
         else                    count_d = sum_s[COUNT_W-1:0];
         if (count_d == '0) begin
            go_d  = 1'b1;
            run_d = 1'b0;
         end else begin
            go_d  = go_q;
            run_d = run_q;
         end
      end else begin
         div_d = div_q;
      end
   end

   // Game state registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= START_C;
         run_q   <= (AUTO_RUN != 0);
         go_q    <= 1'b0;
         div_q   <= '0;
      end else begin
         count_q <= count_d;
         run_q   <= run_d;
         go_q    <= go_d;
         div_q   <= div_d;
      end
   end

   assign adj_s = add3(bcd_q);

   // Converter next state: capture, COUNT_W add-3/shift steps, publish; changes coalesce into one pending request.
   always_comb begin
      cv_d        = cv_q;
      req_d       = req_q;
      it_d        = it_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      timer_bcd_d = timer_bcd_q;
      case (cv_q)
         CV_IDLE: begin
            if (req_q) begin
               req_d = 1'b0;
               bin_d = count_q;
               bcd_d = '0;
               it_d  = '0;
               cv_d  = CV_SHIFT;
            end else begin
               cv_d = CV_IDLE;
            end
         end
         CV_SHIFT: begin
            bcd_d = {adj_s[BW-2:0], bin_q[COUNT_W-1]};
            bin_d = {bin_q[COUNT_W-2:0], 1'b0};
            if (it_q == IT_LAST) cv_d = CV_DONE;
            else                 it_d = it_q + 1'b1;
         end
         CV_DONE: begin
            timer_bcd_d = bcd_q;
            cv_d        = CV_IDLE;
         end
         default: cv_d = CV_IDLE;
      endcase
      if (count_d != count_q) req_d = 1'b1;
      else                    req_d = req_d;
   end

   // Converter registers; reset aborts any conversion and leaves one request pending.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cv_q        <= CV_IDLE;
         req_q       <= 1'b1;
         it_q        <= '0;
         bin_q       <= '0;
         bcd_q       <= '0;
         timer_bcd_q <= '0;
      end else begin
         cv_q        <= cv_d;
         req_q       <= req_d;
         it_q        <= it_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         timer_bcd_q <= timer_bcd_d;
      end
   end

   assign sel_s   = scan_q[MUX_BITS-1 -: 3];
   assign bcd32_s = 32'(timer_bcd_q);

   // Display pattern for the digit selected by the scan counter; unused slots blank.
   always_comb begin
      an_d  = 8'hFF;
      seg_d = 7'd0;
      dp_d  = 1'b0;
      if (int'(sel_s) < DIGITS) begin
         an_d[sel_s] = 1'b0;
         seg_d       = seg_decode(bcd32_s[{sel_s, 2'b00} +: 4]);
         dp_d        = (int'(sel_s) == DP_POS);
      end else begin
         an_d = 8'hFF;
      end
   end

   // Free-running scan counter and registered display pins.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scan_q <= '0;
         an_q   <= 8'hFF;
         seg_q  <= 7'd0;
         dp_q   <= 1'b0;
      end else begin
         scan_q <= scan_q + 1'b1;
         an_q   <= an_d;
         seg_q  <= seg_d;
         dp_q   <= dp_d;
      end
   end

   assign timer_out = count_q;
   assign timer_bcd = timer_bcd_q;
   assign running   = run_q;
   assign game_over = go_q;
   assign seg       = seg_q;
   assign dp        = dp_q;
   assign an        = an_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer with a small configuration:
// TICK_DIV=4, COUNT_W=8, START=25, MAX_VALUE=57, 4 digits, dp on digit 1.
`timescale 1ns/1ps
module tb_game_countdown_timer;

   logic        clock, reset, start, pause, miss, bonus;
   logic [7:0]  timer_out;
   logic [15:0] timer_bcd;
   logic        running, game_over;
   logic [6:0]  seg;
   logic        dp;
   logic [7:0]  an;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;

   game_countdown_timer #(
      .TICK_DIV(4), .COUNT_W(8), .START(25), .MAX_VALUE(57),
      .PENALTY(10), .BONUS(10), .DIGITS(4), .DP_POS(1),
      .MUX_BITS(6), .AUTO_RUN(1)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .pause(pause),
      .miss(miss), .bonus(bonus), .timer_out(timer_out),
      .timer_bcd(timer_bcd), .running(running), .game_over(game_over),
      .seg(seg), .dp(dp), .an(an)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Posedges since reset release; the scan counter starts from the same point.
   always @(posedge clock or posedge reset) begin
      if (reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   logic [7:0] an_tbl  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
   logic [6:0] seg_tbl [8] = '{7'h7D, 7'h6D, 7'h3F, 7'h3F, 7'h00, 7'h00, 7'h00, 7'h00};
   logic       dp_tbl  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      int sel;
      reset = 1'b1; start = 1'b0; pause = 1'b0; miss = 1'b0; bonus = 1'b0;
      step(2);
      chk("rst_count", 32'(timer_out), 32'd25);
      chk("rst_running", 32'(running), 32'd1);
      chk("rst_game_over", 32'(game_over), 32'd0);
      chk("rst_bcd", 32'(timer_bcd), 32'h0);
      chk("rst_an", 32'(an), 32'hFF);
      reset = 1'b0;

      // Free countdown: one tick every 4 cycles, first at the 4th edge.
      step(3);  chk("cnt_at3", 32'(timer_out), 32'd25);
      step(1);  chk("cnt_at4", 32'(timer_out), 32'd24);
      step(4);  chk("cnt_at8", 32'(timer_out), 32'd23);
      step(1);  chk("bcd_at9", 32'(timer_bcd), 32'h0);
      step(1);  chk("bcd_at10", 32'(timer_bcd), 32'h0025);

      // Start reload, penalty, penalty with tick, clamp to zero.
      start = 1'b1; step(1); start = 1'b0;
      chk("start_count", 32'(timer_out), 32'd25);
      miss = 1'b1; step(1); miss = 1'b0;
      chk("miss_25", 32'(timer_out), 32'd15);
      step(2);  chk("hold_15", 32'(timer_out), 32'd15);
      miss = 1'b1; step(1); miss = 1'b0;
      chk("miss_tick_15", 32'(timer_out), 32'd4);
      miss = 1'b1; step(1); miss = 1'b0;
      chk("clamp_zero", 32'(timer_out), 32'd0);
      chk("over_set", 32'(game_over), 32'd1);
      chk("over_run", 32'(running), 32'd0);
      bonus = 1'b1; step(1); bonus = 1'b0;
      step(80);
      chk("over_hold", 32'(timer_out), 32'd0);
      chk("over_flag_hold", 32'(game_over), 32'd1);
      start = 1'b1; step(1); start = 1'b0;
      chk("restart_count", 32'(timer_out), 32'd25);
      chk("restart_over", 32'(game_over), 32'd0);
      chk("restart_run", 32'(running), 32'd1);

      // Pause for 50 cycles at divider phase 2, with an ignored miss.
      step(2);
      pause = 1'b1; step(20);
      miss = 1'b1; step(1); miss = 1'b0;
      step(29);
      chk("pause_hold", 32'(timer_out), 32'd25);
      pause = 1'b0; step(1);
      chk("resume_phase3", 32'(timer_out), 32'd25);
      step(1);
      chk("resume_tick", 32'(timer_out), 32'd24);

      // Bonus saturation and combined events.
      bonus = 1'b1; step(3);
      chk("bonus_x3", 32'(timer_out), 32'd54);
      step(1);
      chk("bonus_tick_sat", 32'(timer_out), 32'd57);
      step(1);
      chk("bonus_at_max", 32'(timer_out), 32'd57);
      miss = 1'b1; step(1); bonus = 1'b0; miss = 1'b0;
      chk("bonus_miss", 32'(timer_out), 32'd57);
      step(1);
      bonus = 1'b1; miss = 1'b1; step(1); bonus = 1'b0; miss = 1'b0;
      chk("bonus_miss_tick", 32'(timer_out), 32'd56);
      pause = 1'b1;
      step(30);
      chk("bcd_56", 32'(timer_bcd), 32'h0056);

      // Display scan over one full counter period.
      for (int i = 0; i < 64; i++) begin
         step(1);
         sel = ((cyc - 1) % 64) / 8;
         chk($sformatf("scan_an_s%0d", sel), 32'(an), 32'(an_tbl[sel]));
         chk($sformatf("scan_seg_s%0d", sel), 32'(seg), 32'(seg_tbl[sel]));
         chk($sformatf("scan_dp_s%0d", sel), 32'(dp), 32'(dp_tbl[sel]));
      end

      // Conversion latency and coalescing of a mid-conversion change.
      pause = 1'b0; miss = 1'b1; step(1); miss = 1'b0;
      chk("co_miss", 32'(timer_out), 32'd46);
      step(2);
      miss = 1'b1; step(1); miss = 1'b0; pause = 1'b1;
      chk("co_miss_tick", 32'(timer_out), 32'd35);
      chk("co_bcd_mid", 32'(timer_bcd), 32'h0056);
      step(6);  chk("co_bcd_u9", 32'(timer_bcd), 32'h0056);
      step(1);  chk("co_bcd_u10", 32'(timer_bcd), 32'h0046);
      step(9);  chk("co_bcd_u19", 32'(timer_bcd), 32'h0046);
      step(1);  chk("co_bcd_u20", 32'(timer_bcd), 32'h0035);
      step(20); chk("co_bcd_final", 32'(timer_bcd), 32'h0035);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
